// File: rtl/dap_ahb_mem_bridge.sv
// AHB-Lite subordinate that turns bus transfers into the single-cycle MEM register
// interface of a peripheral register file, with programmable wait states and ERROR responses.
module dap_ahb_mem_bridge #(
  parameter int ADDRWIDTH   = 12,
  parameter int ADDR_SIZE   = 40,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 hsel,
  input  logic [31:0]          haddr,
  input  logic [1:0]           htrans,
  input  logic [2:0]           hsize,
  input  logic                 hwrite,
  input  logic                 hready,
  input  logic [31:0]          hwdata,
  output logic                 hreadyout,
  output logic                 hresp,
  output logic [31:0]          hrdata,
  output logic                 mem_write_en,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_byte_strobe,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [ADDRWIDTH-1:0] ADDR_LIM = ADDRWIDTH'(ADDR_SIZE);
  localparam logic [3:0] WS_LOAD = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 wr_q, wr_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [3:0]           strb_q, strb_d;

  logic       can_accept;
  logic       accept;
  logic       legal;
  logic [3:0] strb_new;
  logic       unused_haddr;

  assign unused_haddr = ^haddr[31:ADDRWIDTH];

  // Only the final data-phase cycles can overlap a new address phase.
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_LAST) || (state_q == ST_ERR2);
  assign accept     = can_accept && hsel && htrans[1] && hready;

  always_comb begin
    legal    = 1'b1;
    strb_new = 4'b0000;
    case (hsize)
      3'd0: strb_new = 4'b0001 << haddr[1:0];
      3'd1: begin
        strb_new = haddr[1] ? 4'b1100 : 4'b0011;
        if (haddr[0]) legal = 1'b0;
      end
      3'd2: begin
        strb_new = 4'b1111;
        if (haddr[1:0] != 2'b00) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (haddr[ADDRWIDTH-1:0] >= ADDR_LIM) legal = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_LAST;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (accept) begin
          if (legal) begin
            wr_d   = hwrite;
            addr_d = haddr[ADDRWIDTH-1:0];
            strb_d = strb_new;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = WS_LOAD;
            end else begin
              state_d = ST_LAST;
            end
          end else begin
            state_d = ST_ERR1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      strb_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
    end
  end

  assign hreadyout       = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign hresp           = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign mem_write_en    = (state_q == ST_LAST) && wr_q;
  assign mem_addr        = addr_q;
  assign mem_byte_strobe = strb_q;
  assign mem_wdata       = hwdata;
  assign hrdata          = (((state_q == ST_WAIT) || (state_q == ST_LAST)) && !wr_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dap_ahb_mem_bridge.sv
// Directed bench for dap_ahb_mem_bridge: one instance with no wait states, one with three.
module tb_dap_ahb_mem_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic        hready;
  logic [31:0] hwdata;

  logic        rdy0, resp0, we0, rdy3, resp3, we3;
  logic [31:0] hrdata0, wdata0, rdata0, hrdata3, wdata3, rdata3;
  logic [11:0] addr0, addr3;
  logic [3:0]  strb0, strb3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Peripheral model: read data is a tag plus the selected register address.
  assign rdata0 = 32'hC0DE_0000 | {20'h0, addr0};
  assign rdata3 = 32'hC0DE_0000 | {20'h0, addr3};

  dap_ahb_mem_bridge #(.ADDRWIDTH(12), .ADDR_SIZE(40), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .resetn(resetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .hready(hready), .hwdata(hwdata),
    .hreadyout(rdy0), .hresp(resp0), .hrdata(hrdata0), .mem_write_en(we0),
    .mem_addr(addr0), .mem_wdata(wdata0), .mem_byte_strobe(strb0), .mem_rdata(rdata0)
  );

  dap_ahb_mem_bridge #(.ADDRWIDTH(12), .ADDR_SIZE(40), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .resetn(resetn), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hsize(hsize), .hwrite(hwrite), .hready(hready), .hwdata(hwdata),
    .hreadyout(rdy3), .hresp(resp3), .hrdata(hrdata3), .mem_write_en(we3),
    .mem_addr(addr3), .mem_wdata(wdata3), .mem_byte_strobe(strb3), .mem_rdata(rdata3)
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        e_rdy;
    logic        e_resp;
    logic        e_we;
    logic [11:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'd0; hsize = 3'd2; hwrite = 1'b0; haddr = 32'h0;
  endtask

  task automatic addr_phase(input logic wr, input logic [2:0] sz, input logic [31:0] a);
    hsel = 1'b1; htrans = 2'd2; hsize = sz; hwrite = wr; haddr = a;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus_idle();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    int lows;
    int strobes;
    bit done;

    hready = 1'b1;
    hwdata = 32'h0;
    bus_idle();
    do_reset();

    @(negedge clk);
    chk("rst_hreadyout", {31'h0, rdy0}, 32'h1);
    chk("rst_hresp", {31'h0, resp0}, 32'h0);
    chk("rst_we", {31'h0, we0}, 32'h0);
    chk("rst_addr", {20'h0, addr0}, 32'h0);
    chk("rst_strb", {28'h0, strb0}, 32'h0);
    chk("rst_hrdata", hrdata0, 32'h0);

    // sel trans size wr addr wdata | rdy resp we addr strb rdata
    vecs[0]  = '{1'b1, 2'd2, 3'd2, 1'b1, 32'h4000_0008, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 12'h008, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 2'd2, 3'd0, 1'b1, 32'h0000_0006, 32'h00AB_0000, 1'b1, 1'b0, 1'b1, 12'h006, 4'h4, 32'h0};
    vecs[2]  = '{1'b1, 2'd2, 3'd2, 1'b0, 32'h0000_0004, 32'h0,         1'b1, 1'b0, 1'b0, 12'h004, 4'hF, 32'hC0DE_0004};
    vecs[3]  = '{1'b1, 2'd2, 3'd1, 1'b0, 32'h0000_0002, 32'h0,         1'b1, 1'b0, 1'b0, 12'h002, 4'hC, 32'hC0DE_0002};
    vecs[4]  = '{1'b1, 2'd2, 3'd1, 1'b1, 32'h0000_0000, 32'h0000_BEEF, 1'b1, 1'b0, 1'b1, 12'h000, 4'h3, 32'h0};
    vecs[5]  = '{1'b1, 2'd2, 3'd2, 1'b1, 32'h0000_0002, 32'hDEAD_0001, 1'b0, 1'b1, 1'b0, 12'h000, 4'h3, 32'h0};
    vecs[6]  = '{1'b1, 2'd2, 3'd2, 1'b0, 32'h0000_0028, 32'h0,         1'b0, 1'b1, 1'b0, 12'h000, 4'h3, 32'h0};
    vecs[7]  = '{1'b1, 2'd2, 3'd3, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 1'b0, 12'h000, 4'h3, 32'h0};
    vecs[8]  = '{1'b1, 2'd2, 3'd1, 1'b1, 32'h0000_0005, 32'hDEAD_0002, 1'b0, 1'b1, 1'b0, 12'h000, 4'h3, 32'h0};
    vecs[9]  = '{1'b1, 2'd1, 3'd2, 1'b1, 32'h0000_0010, 32'hDEAD_0003, 1'b1, 1'b0, 1'b0, 12'h000, 4'h3, 32'h0};
    vecs[10] = '{1'b0, 2'd2, 3'd2, 1'b1, 32'h0000_0010, 32'hDEAD_0004, 1'b1, 1'b0, 1'b0, 12'h000, 4'h3, 32'h0};
    vecs[11] = '{1'b1, 2'd2, 3'd0, 1'b0, 32'h0000_0027, 32'h0,         1'b1, 1'b0, 1'b0, 12'h027, 4'h8, 32'hC0DE_0027};
    vecs[12] = '{1'b1, 2'd3, 3'd0, 1'b1, 32'h0000_0021, 32'h1122_3344, 1'b1, 1'b0, 1'b1, 12'h021, 4'h2, 32'h0};
    vecs[13] = '{1'b1, 2'd0, 3'd2, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 1'b0, 1'b0, 12'h021, 4'h2, 32'h0};
    vecs[14] = '{1'b1, 2'd2, 3'd1, 1'b0, 32'h0000_0026, 32'h0,         1'b1, 1'b0, 1'b0, 12'h026, 4'hC, 32'hC0DE_0026};
    vecs[15] = '{1'b1, 2'd2, 3'd0, 1'b0, 32'h0000_0028, 32'h0,         1'b0, 1'b1, 1'b0, 12'h026, 4'hC, 32'h0};

    for (int i = 0; i < 16; i++) begin
      hsel = vecs[i].sel; htrans = vecs[i].trans; hsize = vecs[i].size;
      hwrite = vecs[i].wr; haddr = vecs[i].addr;
      @(posedge clk);
      #1;
      bus_idle();
      hwdata = vecs[i].wdata;
      @(negedge clk);
      chk($sformatf("v%0d_hreadyout", i), {31'h0, rdy0}, {31'h0, vecs[i].e_rdy});
      chk($sformatf("v%0d_hresp", i), {31'h0, resp0}, {31'h0, vecs[i].e_resp});
      chk($sformatf("v%0d_we", i), {31'h0, we0}, {31'h0, vecs[i].e_we});
      chk($sformatf("v%0d_addr", i), {20'h0, addr0}, {20'h0, vecs[i].e_addr});
      chk($sformatf("v%0d_strb", i), {28'h0, strb0}, {28'h0, vecs[i].e_strb});
      chk($sformatf("v%0d_hrdata", i), hrdata0, vecs[i].e_rdata);
      if (vecs[i].e_we) chk($sformatf("v%0d_wdata", i), wdata0, vecs[i].wdata);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk($sformatf("v%0d_c2_hreadyout", i), {31'h0, rdy0}, 32'h1);
      chk($sformatf("v%0d_c2_hresp", i), {31'h0, resp0}, {31'h0, vecs[i].e_resp});
      chk($sformatf("v%0d_c2_we", i), {31'h0, we0}, 32'h0);
    end

    // Back-to-back writes: second address phase overlaps the first write cycle.
    do_reset();
    addr_phase(1'b1, 3'd2, 32'h000);
    @(posedge clk);
    #1;
    hwdata = 32'hAAAA_0001;
    addr_phase(1'b1, 3'd2, 32'h004);
    @(negedge clk);
    chk("b2b_we1", {31'h0, we0}, 32'h1);
    chk("b2b_addr1", {20'h0, addr0}, 32'h000);
    chk("b2b_wdata1", wdata0, 32'hAAAA_0001);
    @(posedge clk);
    #1;
    bus_idle();
    hwdata = 32'hAAAA_0002;
    @(negedge clk);
    chk("b2b_we2", {31'h0, we0}, 32'h1);
    chk("b2b_addr2", {20'h0, addr0}, 32'h004);
    chk("b2b_wdata2", wdata0, 32'hAAAA_0002);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_we3", {31'h0, we0}, 32'h0);

    // Three wait states on a read.
    do_reset();
    addr_phase(1'b0, 3'd2, 32'h00C);
    @(posedge clk);
    #1;
    bus_idle();
    lows = 0;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (rdy3) done = 1'b1;
      else begin
        lows++;
        @(posedge clk);
      end
    end
    chk("ws3_done", {31'h0, done}, 32'h1);
    chk("ws3_low_cycles", lows, 32'd3);
    chk("ws3_hrdata", hrdata3, 32'hC0DE_000C);
    chk("ws3_hresp", {31'h0, resp3}, 32'h0);

    // Wait-stated write issues exactly one strobe.
    do_reset();
    addr_phase(1'b1, 3'd0, 32'h011);
    @(posedge clk);
    #1;
    bus_idle();
    hwdata = 32'h0000_5500;
    strobes = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (we3) begin
        strobes++;
        chk("ws3_wr_addr", {20'h0, addr3}, 32'h011);
        chk("ws3_wr_strb", {28'h0, strb3}, 32'h2);
      end
    end
    chk("ws3_wr_strobes", strobes, 32'd1);

    // Reset asserted during the wait phase of a write aborts it.
    do_reset();
    addr_phase(1'b1, 3'd2, 32'h010);
    @(posedge clk);
    #1;
    bus_idle();
    @(negedge clk);
    chk("abort_in_wait", {31'h0, rdy3}, 32'h0);
    resetn = 1'b0;
    #1;
    chk("abort_hreadyout", {31'h0, rdy3}, 32'h1);
    chk("abort_hresp", {31'h0, resp3}, 32'h0);
    chk("abort_addr", {20'h0, addr3}, 32'h0);
    chk("abort_strb", {28'h0, strb3}, 32'h0);
    strobes = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (we3) strobes++;
    end
    resetn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (we3) strobes++;
    end
    chk("abort_no_strobe", strobes, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
